// File: rtl/alu_input_seq.sv
// Operand/opcode entry sequencer: collects A, B and OP from a shared 4-bit bus on LOAD edges,
// then presents the set to the ALU until the downstream stage accepts it with READY.
module alu_input_seq #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       DIN,
    input  logic             LOAD,
    input  logic             CLR,
    input  logic             READY,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic [1:0]       OP,
    output logic             VALID,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] TXN_CNT
);

    typedef enum logic [1:0] {
        StGetA    = 2'b00,
        StGetB    = 2'b01,
        StGetOp   = 2'b10,
        StPresent = 2'b11
    } state_e;

    state_e           state_q;
    logic             load_q;
    logic             armed_q;
    logic [3:0]       a_q;
    logic [3:0]       b_q;
    logic [1:0]       op_q;
    logic             valid_q;
    logic [CNT_W-1:0] txn_cnt_q;
    logic             load_ev;

    // armed_q blocks a LOAD that was already high when reset released from counting as an edge.
    assign load_ev = LOAD & ~load_q & armed_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= StGetA;
            load_q    <= 1'b0;
            armed_q   <= 1'b0;
            a_q       <= 4'h0;
            b_q       <= 4'h0;
            op_q      <= 2'b00;
            valid_q   <= 1'b0;
            txn_cnt_q <= '0;
        end else begin
            load_q <= LOAD;
            if (!LOAD) begin
                armed_q <= 1'b1;
            end
            if (CLR) begin
                state_q <= StGetA;
                valid_q <= 1'b0;
                a_q     <= 4'h0;
                b_q     <= 4'h0;
                op_q    <= 2'b00;
            end else begin
                unique case (state_q)
                    StGetA: begin
                        if (load_ev) begin
                            a_q     <= DIN;
                            state_q <= StGetB;
                        end
                    end
                    StGetB: begin
                        if (load_ev) begin
                            b_q     <= DIN;
                            state_q <= StGetOp;
                        end
                    end
                    StGetOp: begin
                        if (load_ev) begin
                            op_q    <= DIN[1:0];
                            valid_q <= 1'b1;
                            state_q <= StPresent;
                        end
                    end
                    StPresent: begin
                        if (READY) begin
                            valid_q   <= 1'b0;
                            txn_cnt_q <= txn_cnt_q + CNT_W'(1);
                            state_q   <= StGetA;
                        end
                    end
                    default: state_q <= StGetA;
                endcase
            end
        end
    end

    assign A       = a_q;
    assign B       = b_q;
    assign OP      = op_q;
    assign VALID   = valid_q;
    assign STATE   = state_q;
    assign TXN_CNT = txn_cnt_q;

endmodule

// File: tb/tb_alu_input_seq.sv
// Bench for alu_input_seq: directed scenarios plus random traffic against a stage-counter model.
module tb_alu_input_seq;

    localparam int CNT_W = 8;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [3:0]       DIN;
    logic             LOAD;
    logic             CLR;
    logic             READY;
    logic [3:0]       A;
    logic [3:0]       B;
    logic [1:0]       OP;
    logic             VALID;
    logic [1:0]       STATE;
    logic [CNT_W-1:0] TXN_CNT;

    alu_input_seq #(.CNT_W(CNT_W)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .DIN    (DIN),
        .LOAD   (LOAD),
        .CLR    (CLR),
        .READY  (READY),
        .A      (A),
        .B      (B),
        .OP     (OP),
        .VALID  (VALID),
        .STATE  (STATE),
        .TXN_CNT(TXN_CNT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: entry position 0..3 (3 = set presented), captured fields, completed count.
    int         m_pos;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [1:0] m_op;
    int         m_cnt;
    bit         m_prev_load;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // After reset, pretend LOAD was high so a held LOAD needs a low sample first.
    task automatic model_reset();
        m_pos       = 0;
        m_a         = 4'h0;
        m_b         = 4'h0;
        m_op        = 2'b00;
        m_cnt       = 0;
        m_prev_load = 1'b1;
    endtask

    task automatic model_edge();
        bit ev;
        ev = LOAD && !m_prev_load;
        if (CLR) begin
            m_pos = 0;
            m_a   = 4'h0;
            m_b   = 4'h0;
            m_op  = 2'b00;
        end else if (m_pos == 3) begin
            if (READY) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_pos = 0;
            end
        end else if (ev) begin
            if (m_pos == 0) m_a = DIN;
            else if (m_pos == 1) m_b = DIN;
            else m_op = DIN[1:0];
            m_pos = m_pos + 1;
        end
        m_prev_load = LOAD;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".A"}, A, m_a);
        check({tag, ".B"}, B, m_b);
        check({tag, ".OP"}, OP, m_op);
        check({tag, ".VALID"}, VALID, (m_pos == 3) ? 1 : 0);
        check({tag, ".STATE"}, STATE, m_pos);
        check({tag, ".TXN_CNT"}, TXN_CNT, m_cnt);
    endtask

    task automatic cyc(input logic [3:0] din, input logic load, input logic ready,
                       input logic clr, input string tag);
        DIN   = din;
        LOAD  = load;
        READY = ready;
        CLR   = clr;
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input logic load_during);
        LOAD  = load_during;
        CLR   = 1'b0;
        READY = 1'b0;
        DIN   = 4'h0;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic enter(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        cyc(a, 1'b1, 1'b0, 1'b0, "entA");
        cyc(a, 1'b0, 1'b0, 1'b0, "entA0");
        cyc(b, 1'b1, 1'b0, 1'b0, "entB");
        cyc(b, 1'b0, 1'b0, 1'b0, "entB0");
        cyc(op, 1'b1, 1'b0, 1'b0, "entOP");
    endtask

    initial begin
        RST_N = 1'b1;
        LOAD  = 1'b0;
        CLR   = 1'b0;
        READY = 1'b0;
        DIN   = 4'h0;
        #2;
        do_reset(1'b0);
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "idle");

        // Basic entry and handshake
        enter(4'h5, 4'h3, 4'h2);
        check("basic.A", A, 4'h5);
        check("basic.B", B, 4'h3);
        check("basic.OP", OP, 2'b10);
        check("basic.VALID", VALID, 1'b1);
        check("basic.STATE", STATE, 2'b11);
        cyc(4'h0, 1'b0, 1'b1, 1'b0, "hs");
        check("hs.VALID", VALID, 1'b0);
        check("hs.STATE", STATE, 2'b00);
        check("hs.CNT", TXN_CNT, 8'd1);
        check("hs.keepA", A, 4'h5);

        // LOAD pulses in PRESENT are ignored and not queued
        enter(4'h6, 4'h1, 4'h3);
        for (int i = 0; i < 10; i++) cyc(4'hF, (i % 2 == 0), 1'b0, 1'b0, "pres");
        check("pres.A", A, 4'h6);
        check("pres.OP", OP, 2'b11);
        check("pres.STATE", STATE, 2'b11);
        cyc(4'hF, 1'b0, 1'b1, 1'b0, "pres.hs");
        cyc(4'hF, 1'b0, 1'b0, 1'b0, "pres.after");
        check("noqueue.STATE", STATE, 2'b00);

        // LOAD held high is one event
        for (int i = 0; i < 20; i++) cyc(4'h9, 1'b1, 1'b0, 1'b0, "hold");
        check("hold.A", A, 4'h9);
        check("hold.STATE", STATE, 2'b01);
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "hold.low");

        // CLR beats a simultaneous LOAD edge
        cyc(4'h2, 1'b1, 1'b0, 1'b0, "clrB");
        cyc(4'h2, 1'b0, 1'b0, 1'b0, "clrB0");
        cyc(4'h4, 1'b1, 1'b0, 1'b1, "clr");
        check("clr.STATE", STATE, 2'b00);
        check("clr.A", A, 4'h0);
        check("clr.CNT", TXN_CNT, 8'd2);

        // READY with CLR in PRESENT: no count
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "rc0");
        enter(4'h7, 4'h2, 4'h1);
        cyc(4'h0, 1'b0, 1'b1, 1'b1, "rdyclr");
        check("rdyclr.CNT", TXN_CNT, 8'd2);
        check("rdyclr.VALID", VALID, 1'b0);

        // Asynchronous reset in GET_OP
        cyc(4'hA, 1'b1, 1'b0, 1'b0, "arA");
        cyc(4'hA, 1'b0, 1'b0, 1'b0, "arA0");
        cyc(4'hB, 1'b1, 1'b0, 1'b0, "arB");
        cyc(4'hB, 1'b0, 1'b0, 1'b0, "arB0");
        check("ar.pre", STATE, 2'b10);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_all("async");
        check("async.A", A, 4'h0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;

        // LOAD already high at reset release is not an event
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) cyc(4'hC, 1'b1, 1'b0, 1'b0, "relhi");
        check("relhi.STATE", STATE, 2'b00);
        cyc(4'hC, 1'b0, 1'b0, 1'b0, "rel.low");
        cyc(4'hD, 1'b1, 1'b0, 1'b0, "rel.edge");
        check("rel.A", A, 4'hD);
        cyc(4'hD, 1'b0, 1'b0, 1'b0, "rel.low2");

        // Counter wrap
        do_reset(1'b0);
        cyc(4'h0, 1'b0, 1'b0, 1'b0, "wrap0");
        for (int n = 0; n < 257; n++) begin
            enter(4'($urandom), 4'($urandom), 4'($urandom));
            cyc(4'h0, 1'b0, 1'b1, 1'b0, "wraphs");
            if (n == 255) check("wrap.256", TXN_CNT, 8'd0);
        end
        check("wrap.257", TXN_CNT, 8'd1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset(1'($urandom));
            end else begin
                cyc(4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 39) == 0), "rand");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
